// File: rtl/scs8hd_tapsw_seq.sv
// scs8hd_tapsw_seq: switched-tap power sequencer for one gated domain.
// Ramps NSEG header/tap segments one at a time, SETTLE cycles apart.
//
// Ports:
//   clk       sequencer clock, rising edge
//   resetb    asynchronous active-low reset
//   pwr_req   level request from the PMC (1 = domain on)
//   rbb_mode  apply reverse body bias while the domain is off
//   pwr_ack   domain fully powered and isolation released
//   sw_en     thermometer-coded segment enables (bit 0 first)
//   iso_en    output isolation of the gated domain (1 = isolated)
//   rbb_en    reverse-body-bias enable to the switched taps
//   busy      ramp in progress (up or down)
//
// Power pins (vpwr/vgnd/vpb/vnb) are not modelled in this variant.

module scs8hd_tapsw_seq #(
    parameter int NSEG   = 4,
    parameter int SETTLE = 8
) (
    input  logic            clk,
    input  logic            resetb,
    input  logic            pwr_req,
    input  logic            rbb_mode,
    output logic            pwr_ack,
    output logic [NSEG-1:0] sw_en,
    output logic            iso_en,
    output logic            rbb_en,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_OFF = 2'd0,
        S_UP  = 2'd1,
        S_ON  = 2'd2,
        S_DN  = 2'd3
    } state_t;

    localparam logic [7:0]      CNT_LAST = 8'(SETTLE - 1);
    localparam logic [NSEG-1:0] SEG0     = NSEG'(1);

    state_t          state;
    logic [7:0]      cnt;

    // Segment stepping is a shift so the enables can only ever be
    // a thermometer code, one bit moving per change.
    logic [NSEG-1:0] sw_up;
    logic [NSEG-1:0] sw_dn;
    logic            sw_full;
    logic            settled;

    assign sw_up   = (sw_en << 1) | SEG0;
    assign sw_dn   = sw_en >> 1;
    assign sw_full = &sw_en;
    assign settled = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state   <= S_OFF;
            cnt     <= '0;
            sw_en   <= '0;
            iso_en  <= 1'b1;
            pwr_ack <= 1'b0;
            rbb_en  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                S_OFF: begin
                    cnt <= '0;
                    if (pwr_req) begin
                        // Bias must be off before the first segment
                        // conducts, so both change on one edge.
                        state  <= S_UP;
                        sw_en  <= SEG0;
                        busy   <= 1'b1;
                        rbb_en <= 1'b0;
                    end else begin
                        rbb_en <= rbb_mode;
                    end
                end

                S_UP: begin
                    if (!pwr_req) begin
                        // Reversal: keep segments, restart settle.
                        state <= S_DN;
                        cnt   <= '0;
                    end else if (settled) begin
                        cnt <= '0;
                        if (sw_full) begin
                            state   <= S_ON;
                            pwr_ack <= 1'b1;
                            iso_en  <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            sw_en <= sw_up;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                S_ON: begin
                    cnt <= '0;
                    if (!pwr_req) begin
                        // Isolate first; switches wait a full
                        // settle interval before the first drop.
                        state   <= S_DN;
                        pwr_ack <= 1'b0;
                        iso_en  <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                S_DN: begin
                    if (pwr_req) begin
                        state <= S_UP;
                        cnt   <= '0;
                    end else if (settled) begin
                        cnt   <= '0;
                        sw_en <= sw_dn;
                        if (sw_dn == '0) begin
                            state  <= S_OFF;
                            busy   <= 1'b0;
                            rbb_en <= rbb_mode;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                default: begin
                    state   <= S_OFF;
                    cnt     <= '0;
                    sw_en   <= '0;
                    iso_en  <= 1'b1;
                    pwr_ack <= 1'b0;
                    rbb_en  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scs8hd_tapsw_seq.sv
// tb_scs8hd_tapsw_seq: directed timing scenarios plus a randomized
// run against a segment-level reference model.

module tb_scs8hd_tapsw_seq;

    localparam int NSEG   = 4;
    localparam int SETTLE = 3;
    localparam int RAMP   = NSEG * SETTLE;

    logic            clk = 1'b0;
    logic            resetb;
    logic            pwr_req;
    logic            rbb_mode;
    logic            pwr_ack;
    logic [NSEG-1:0] sw_en;
    logic            iso_en;
    logic            rbb_en;
    logic            busy;

    int checks = 0;
    int errors = 0;

    // reference model: number of segments on, time since last change
    int m_lvl;
    int m_since;
    bit m_pow;
    bit m_ramp;
    bit m_up;
    bit m_rbb;

    scs8hd_tapsw_seq #(
        .NSEG   (NSEG),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .resetb   (resetb),
        .pwr_req  (pwr_req),
        .rbb_mode (rbb_mode),
        .pwr_ack  (pwr_ack),
        .sw_en    (sw_en),
        .iso_en   (iso_en),
        .rbb_en   (rbb_en),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NSEG-1:0] therm(input int n);
        therm = NSEG'((1 << n) - 1);
    endfunction

    function automatic int imin(input int a, input int b);
        imin = (a < b) ? a : b;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_off;
        pwr_req = 1'b0;
        repeat (RAMP + 4) tick();
    endtask

    task automatic go_on;
        pwr_req = 1'b1;
        repeat (RAMP + 4) tick();
    endtask

    task automatic model_step(input bit req, input bit rbbm);
        if (!m_ramp && !m_pow) begin
            if (req) begin
                m_lvl = 1; m_ramp = 1; m_up = 1;
                m_since = 0; m_rbb = 0;
            end else begin
                m_rbb = rbbm;
            end
        end else if (m_pow) begin
            if (!req) begin
                m_pow = 0; m_ramp = 1; m_up = 0; m_since = 0;
            end
        end else if (req != m_up) begin
            m_up = req;
            m_since = 0;
        end else if (m_since + 1 == SETTLE) begin
            m_since = 0;
            if (m_up) begin
                if (m_lvl == NSEG) begin
                    m_pow = 1; m_ramp = 0;
                end else begin
                    m_lvl++;
                end
            end else begin
                m_lvl--;
                if (m_lvl == 0) begin
                    m_ramp = 0;
                    m_rbb = rbbm;
                end
            end
        end else begin
            m_since++;
        end
    endtask

    task automatic test_reset;
        logic [NSEG+3:0] exp;
        resetb   = 1'b0;
        pwr_req  = 1'b0;
        rbb_mode = 1'b1;
        #12;
        exp = {therm(0), 1'b1, 1'b0, 1'b0, 1'b0};
        checks++;
        if ({sw_en, iso_en, pwr_ack, rbb_en, busy} !== exp) begin
            $display("FAIL reset got=%b exp=%b",
                     {sw_en, iso_en, pwr_ack, rbb_en, busy}, exp);
            errors++;
        end
        rbb_mode = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_powerup;
        logic [NSEG+2:0] exp;
        bit ack;
        pwr_req = 1'b1;
        for (int t = 0; t <= RAMP; t++) begin
            tick();
            ack = (t >= RAMP);
            exp = {therm(imin(t / SETTLE + 1, NSEG)), !ack, ack,
                   (t < RAMP)};
            checks++;
            if ({sw_en, iso_en, pwr_ack, busy} !== exp) begin
                $display("FAIL powerup t=%0d got=%b exp=%b", t,
                         {sw_en, iso_en, pwr_ack, busy}, exp);
                errors++;
            end
        end
    endtask

    task automatic test_powerdown;
        logic [NSEG+2:0] exp;
        pwr_req = 1'b0;
        for (int t = 0; t <= RAMP; t++) begin
            tick();
            exp = {therm(NSEG - t / SETTLE), 1'b1, 1'b0, (t < RAMP)};
            checks++;
            if ({sw_en, iso_en, pwr_ack, busy} !== exp) begin
                $display("FAIL powerdown t=%0d got=%b exp=%b", t,
                         {sw_en, iso_en, pwr_ack, busy}, exp);
                errors++;
            end
        end
    endtask

    task automatic test_abort_up;
        logic [NSEG+2:0] exp;
        int lvl;
        pwr_req = 1'b1;
        for (int t = 0; t <= 10; t++) begin
            if (t == 4) pwr_req = 1'b0;
            tick();
            lvl = (t < 4) ? imin(t / SETTLE + 1, NSEG)
                          : 2 - (t - 4) / SETTLE;
            exp = {therm(lvl), 1'b1, 1'b0, (t < 10)};
            checks++;
            if ({sw_en, iso_en, pwr_ack, busy} !== exp) begin
                $display("FAIL abort_up t=%0d got=%b exp=%b", t,
                         {sw_en, iso_en, pwr_ack, busy}, exp);
                errors++;
            end
        end
    endtask

    task automatic test_abort_down;
        logic [NSEG+2:0] exp;
        int lvl;
        bit ack;
        go_on();
        for (int t = 0; t <= 10; t++) begin
            if (t == 0) pwr_req = 1'b0;
            if (t == 4) pwr_req = 1'b1;
            tick();
            lvl = (t < 4) ? NSEG - t / SETTLE
                          : imin(3 + (t - 4) / SETTLE, NSEG);
            ack = (t >= 10);
            exp = {therm(lvl), !ack, ack, (t < 10)};
            checks++;
            if ({sw_en, iso_en, pwr_ack, busy} !== exp) begin
                $display("FAIL abort_down t=%0d got=%b exp=%b", t,
                         {sw_en, iso_en, pwr_ack, busy}, exp);
                errors++;
            end
        end
    endtask

    task automatic test_rbb;
        go_off();
        rbb_mode = 1'b1;
        tick();
        checks++;
        if (rbb_en !== 1'b1) begin
            $display("FAIL rbb_off got=%b exp=1", rbb_en);
            errors++;
        end
        pwr_req = 1'b1;
        tick();
        checks++;
        if ({rbb_en, sw_en} !== {1'b0, therm(1)}) begin
            $display("FAIL rbb_up got=%b exp=%b", {rbb_en, sw_en},
                     {1'b0, therm(1)});
            errors++;
        end
        pwr_req = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            tick();
            checks++;
            if ({rbb_en, sw_en} !== {(t >= 4), therm(t < 4)}) begin
                $display("FAIL rbb_back t=%0d got=%b exp=%b", t,
                         {rbb_en, sw_en}, {(t >= 4), therm(t < 4)});
                errors++;
            end
        end
        rbb_mode = 1'b0;
        tick();
        checks++;
        if (rbb_en !== 1'b0) begin
            $display("FAIL rbb_clear got=%b exp=0", rbb_en);
            errors++;
        end
    endtask

    task automatic test_reset_midramp;
        logic [NSEG+2:0] exp;
        bit ack;
        go_off();
        pwr_req = 1'b1;
        repeat (5) tick();
        checks++;
        if (sw_en !== therm(2)) begin
            $display("FAIL midramp_pre got=%b exp=%b", sw_en, therm(2));
            errors++;
        end
        #2;
        resetb = 1'b0;
        #1;
        checks++;
        if ({sw_en, iso_en, pwr_ack, rbb_en, busy} !==
            {therm(0), 1'b1, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL midramp_rst got=%b exp=%b",
                     {sw_en, iso_en, pwr_ack, rbb_en, busy},
                     {therm(0), 1'b1, 1'b0, 1'b0, 1'b0});
            errors++;
        end
        @(negedge clk);
        resetb = 1'b1;
        for (int t = 0; t <= RAMP; t++) begin
            tick();
            ack = (t >= RAMP);
            exp = {therm(imin(t / SETTLE + 1, NSEG)), !ack, ack,
                   (t < RAMP)};
            checks++;
            if ({sw_en, iso_en, pwr_ack, busy} !== exp) begin
                $display("FAIL midramp_ramp t=%0d got=%b exp=%b", t,
                         {sw_en, iso_en, pwr_ack, busy}, exp);
                errors++;
            end
        end
        go_off();
    endtask

    task automatic test_random;
        logic [NSEG+3:0] exp;
        rbb_mode = 1'b0;
        go_off();
        m_lvl = 0; m_since = 0; m_pow = 0;
        m_ramp = 0; m_up = 0; m_rbb = 0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) pwr_req = ~pwr_req;
            if ($urandom_range(0, 5) == 0) rbb_mode = ~rbb_mode;
            model_step(pwr_req, rbb_mode);
            tick();
            exp = {therm(m_lvl), !m_pow, m_pow, m_rbb, m_ramp};
            checks++;
            if ({sw_en, iso_en, pwr_ack, rbb_en, busy} !== exp) begin
                $display("FAIL random i=%0d got=%b exp=%b", i,
                         {sw_en, iso_en, pwr_ack, rbb_en, busy}, exp);
                errors++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_powerdown();
        test_abort_up();
        test_abort_down();
        test_rbb();
        test_reset_midramp();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scs8hd_tapsw_seq.md
# scs8hd_tapsw_seq

Switched-tap power sequencer for scs8hd power-gated regions. It extends the plain well-tap idea into switched segments: it turns on NSEG header-switch/tap segments one at a time, spaced by a fixed settle interval, so that in-rush current stays bounded. It drives output isolation and an optional reverse-body-bias enable while the domain is off. It sits between the power-management controller (pwr_req/pwr_ack) and the switch and tap segments of one gated domain.

## Interface
- NSEG, 4: number of switch/tap segments, legal 1..16
- SETTLE, 8: cycles between successive segment changes, legal 1..255
- clk  input  1  sequencer clock, rising edge
- resetb  input  1  asynchronous, active-low reset
- pwr_req  input  1  level request: 1 = domain on, 0 = domain off
- rbb_mode  input  1  1 = apply reverse body bias while the domain is OFF
- pwr_ack  output  1  1 only in ON (fully powered, isolation released)
- sw_en  output  NSEG  segment enables, always thermometer-coded from bit 0
- iso_en  output  1  output isolation of the gated domain, 1 = isolated
- rbb_en  output  1  reverse-body-bias enable to the switched taps
- busy  output  1  1 in UP or DN
- vpwr, vgnd, vpb, vnb  input  1 each  present only when PG pins are enabled

## Operation
- One clock; reset is asynchronous and active-low.
- All outputs are registered. Reset values: state=OFF, sw_en=0, iso_en=1, pwr_ack=0, rbb_en=0, busy=0, settle counter=0.
- States are OFF, UP, ON and DN. A settle counter cnt counts 0..SETTLE-1 and is cleared on every state entry and every segment change.
- OFF:
  - pwr_req=1 → go to UP. On the same edge set sw_en[0]=1, busy=1 and rbb_en=0.
  - Otherwise rbb_en<=rbb_mode. rbb_mode is re-sampled every OFF cycle.
- UP, with pwr_req=1, when cnt==SETTLE-1:
  - If sw_en is all ones → go to ON: pwr_ack=1, iso_en=0, busy=0.
  - Otherwise set the next sw_en bit (the lowest zero bit).
- UP, with pwr_req=0 (abort) → go to DN immediately, cnt=0, sw_en unchanged.
- ON: pwr_req=0 → go to DN. On the same edge pwr_ack=0, iso_en=1, busy=1. Switches are untouched on this edge, so isolation always precedes switch-off by SETTLE cycles.
- DN, with pwr_req=0, when cnt==SETTLE-1:
  - Clear the highest set sw_en bit.
  - If sw_en becomes 0 → go to OFF: busy=0, rbb_en<=rbb_mode.
- DN, with pwr_req=1 (abort) → go to UP, cnt=0, sw_en unchanged, iso_en stays 1.
- iso_en=0 only in ON. pwr_ack=1 only in ON. rbb_en=1 only in OFF.
- sw_en never changes by more than one bit per edge and never holds a non-thermometer value.
- Reset asserted mid-ramp: all outputs go to their reset values immediately (asynchronously). Switches drop at once; this is accepted as an emergency path.

## Timing
- Power-up latency: pwr_req is sampled high at edge E0 (in OFF).
  - sw_en[k] rises at edge E0 + k*SETTLE.
  - pwr_ack and iso_en change at edge E0 + NSEG*SETTLE.
- Power-down latency: pwr_req is sampled low at edge F0 (in ON).
  - iso_en=1 and pwr_ack=0 at F0.
  - sw_en[NSEG-k] falls at F0 + k*SETTLE, for k=1..NSEG.
  - The last switch off and entry to OFF happen at F0 + NSEG*SETTLE.
- SETTLE=1: one segment change per cycle; up and down latency are each NSEG cycles.
- NSEG=1: ramp is a single segment; latency is SETTLE cycles each way.
- Aborts never skip the settle interval: the first segment change after a direction reversal occurs SETTLE cycles after the reversal edge.
- pwr_req glitches shorter than one cycle are not filtered; pwr_req is assumed synchronous to clk.

## Test plan
- NSEG=4, SETTLE=3, pwr_req 0→1 sampled at cycle 10 → sw_en = 0001@10, 0011@13, 0111@16, 1111@19; pwr_ack=1 and iso_en=0 @22; busy=1 for cycles 10..21.
- From ON, pwr_req→0 sampled at cycle 40 → iso_en=1 and pwr_ack=0 @40; sw_en = 0111@43, 0011@46, 0001@49, 0000@52 with state OFF @52.
- Abort up: pwr_req high at 10, low at 14 (sw_en=0011) → DN @14; sw_en = 0001@17, 0000@20; pwr_ack never 1; iso_en held 1 throughout.
- Abort down: from ON, pwr_req low at 40, high at 44 (sw_en=0111) → UP @44; sw_en=1111@47; ON @50 with pwr_ack=1.
- rbb_mode=1 in OFF → rbb_en=1 one cycle later; pwr_req rises → rbb_en=0 on the same edge as sw_en[0]=1; rbb_en returns to 1 on the edge OFF is re-entered.
- resetb low at cycle 15 during UP (sw_en=0011) → immediately sw_en=0, iso_en=1, pwr_ack=0, rbb_en=0, busy=0; after release with pwr_req=1, the full 12-cycle ramp restarts from sw_en=0001.
